// File: rtl/sensor_avg_bank.sv
// Multi-channel leaky-integrator sensor averager with error output.
// Optional peak-hold output is enabled by defining AVG_PEAK_HOLD_EN.
module sensor_avg_bank #(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 12,
  parameter int MAX_SH        = 5,
  parameter int DEF_SH        = 2,
  parameter int PERIOD_W      = 22,
  parameter int FAST_PERIOD_W = 16,
  parameter int FAST_SIM      = 0,
  parameter int ERR_CH        = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   sample,
  input  logic [NUM_CH-1:0]          strobe,
  input  logic [NUM_CH-1:0]          mode,
  input  logic [NUM_CH-1:0]          seed,
  input  logic [NUM_CH*3-1:0]        shift,
  input  logic [DATA_W-1:0]          target,
  input  logic                       err_gate,
  output logic [NUM_CH*DATA_W-1:0]   avg,
  output logic [NUM_CH-1:0]          avg_vld,
  output logic                       tick,
  output logic [DATA_W:0]            error
`ifdef AVG_PEAK_HOLD_EN
  ,
  output logic [NUM_CH*DATA_W-1:0]   peak
`endif
);

  localparam int ACC_W = DATA_W + MAX_SH;
  localparam int PW    = (FAST_SIM != 0) ? FAST_PERIOD_W : PERIOD_W;
  localparam int SH_W  = 3;
  localparam logic [SH_W-1:0] SH_MAX = SH_W'(MAX_SH);
  localparam logic [SH_W-1:0] SH_DEF = SH_W'(DEF_SH);

  logic [PW-1:0]     timer_q, timer_d;
  logic              tick_q, tick_d;
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [SH_W-1:0]   sh_q  [NUM_CH];
  logic [SH_W-1:0]   sh_d  [NUM_CH];
  logic [SH_W-1:0]   cl_sh [NUM_CH];
  logic [DATA_W-1:0] smp   [NUM_CH];
  logic [DATA_W-1:0] avg_q [NUM_CH];
  logic [DATA_W-1:0] avg_d [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] vld_q, vld_d;
  logic [DATA_W:0]   err_q, err_d;

  // tick is high in the same cycle the counter reads all-ones
  always_comb begin
    timer_d = timer_q + PW'(1);
    tick_d  = &timer_d;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      smp[c]   = sample[c*DATA_W +: DATA_W];
      cl_sh[c] = shift[c*SH_W +: SH_W];
      if (cl_sh[c] == '0) begin
        cl_sh[c] = SH_W'(1);
      end else if (cl_sh[c] > SH_MAX) begin
        cl_sh[c] = SH_MAX;
      end
      en[c]    = mode[c] ? strobe[c] : tick_q;
      acc_d[c] = acc_q[c];
      sh_d[c]  = sh_q[c];
      vld_d[c] = 1'b0;
      if (seed[c]) begin
        sh_d[c]  = cl_sh[c];
        acc_d[c] = ACC_W'(smp[c]) << cl_sh[c];
        vld_d[c] = 1'b1;
      end else if (en[c]) begin
        acc_d[c] = acc_q[c] - (acc_q[c] >> sh_q[c])
                 + ACC_W'(smp[c]);
        vld_d[c] = 1'b1;
      end
      avg_d[c] = DATA_W'(acc_d[c] >> sh_d[c]);
    end
  end

  always_comb begin
    if (err_gate) begin
      err_d = '0;
    end else begin
      err_d = {1'b0, target} - {1'b0, avg_q[ERR_CH]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      tick_q  <= 1'b0;
      vld_q   <= '0;
      err_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        sh_q[c]  <= SH_DEF;
        avg_q[c] <= '0;
      end
    end else begin
      timer_q <= timer_d;
      tick_q  <= tick_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        sh_q[c]  <= sh_d[c];
        avg_q[c] <= avg_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      avg[c*DATA_W +: DATA_W] = avg_q[c];
    end
    avg_vld = vld_q;
    tick    = tick_q;
    error   = err_q;
  end

`ifdef AVG_PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_q [NUM_CH];
  logic [DATA_W-1:0] peak_d [NUM_CH];

  // seed restarts the peak from the seeded average
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      peak_d[c] = peak_q[c];
      if (seed[c]) begin
        peak_d[c] = avg_d[c];
      end else if (en[c] && (avg_d[c] > peak_q[c])) begin
        peak_d[c] = avg_d[c];
      end
      peak[c*DATA_W +: DATA_W] = peak_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        peak_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        peak_q[c] <= peak_d[c];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sensor_avg_bank.sv
// Directed testbench for sensor_avg_bank (FAST_SIM timer).
// Covers seed, strobe averaging, error, clamp, reset, tick, peak.
module tb_sensor_avg_bank;

  localparam int NUM_CH = 4;
  localparam int DW     = 12;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_CH*DW-1:0]   sample;
  logic [NUM_CH-1:0]      strobe;
  logic [NUM_CH-1:0]      mode;
  logic [NUM_CH-1:0]      seed;
  logic [NUM_CH*3-1:0]    shift;
  logic [DW-1:0]          target;
  logic                   err_gate;
  logic [NUM_CH*DW-1:0]   avg;
  logic [NUM_CH-1:0]      avg_vld;
  logic                   tick;
  logic [DW:0]            error;
`ifdef AVG_PEAK_HOLD_EN
  logic [NUM_CH*DW-1:0]   peak;
`endif

  int vecs = 0;
  int errs = 0;

  sensor_avg_bank #(
    .NUM_CH(NUM_CH), .DATA_W(DW), .MAX_SH(5), .DEF_SH(2),
    .PERIOD_W(22), .FAST_PERIOD_W(16), .FAST_SIM(1), .ERR_CH(0)
  ) dut (
    .clk(clk), .rst(rst), .sample(sample), .strobe(strobe),
    .mode(mode), .seed(seed), .shift(shift), .target(target),
    .err_gate(err_gate), .avg(avg), .avg_vld(avg_vld),
    .tick(tick), .error(error)
`ifdef AVG_PEAK_HOLD_EN
    , .peak(peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sample = '0; strobe = '0; mode = '1; seed = '0;
    shift = {4{3'd2}}; target = '0; err_gate = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (avg !== '0 || avg_vld !== '0 || tick !== 1'b0 || error !== '0) begin
      errs++;
      $display("FAIL reset_outputs: avg=%h vld=%b tick=%b err=%h, want all 0",
               avg, avg_vld, tick, error);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      vecs++;
      if (dut.sh_q[c] !== 3'd2 || dut.acc_q[c] !== '0) begin
        errs++;
        $display("FAIL reset_state ch%0d: sh=%0d acc=%h, want sh=2 acc=0",
                 c, dut.sh_q[c], dut.acc_q[c]);
      end
    end
  endtask

  task automatic test_seed();
    do_reset();
    sample[0 +: DW] = 12'h400;
    shift[0 +: 3] = 3'd2;
    seed[0] = 1'b1;
    step();
    seed[0] = 1'b0;
    vecs++;
    if (avg[0 +: DW] !== 12'h400 || avg_vld[0] !== 1'b1) begin
      errs++;
      $display("FAIL seed_avg: avg0=%h vld=%b, want 400 1",
               avg[0 +: DW], avg_vld[0]);
    end
    vecs++;
    if (dut.acc_q[0] !== 17'h01000) begin
      errs++;
      $display("FAIL seed_acc: acc0=%h, want 01000", dut.acc_q[0]);
    end
    step();
    vecs++;
    if (avg_vld[0] !== 1'b0 || avg[0 +: DW] !== 12'h400) begin
      errs++;
      $display("FAIL seed_pulse: vld=%b avg0=%h, want 0 400",
               avg_vld[0], avg[0 +: DW]);
    end
  endtask

  task automatic test_strobe();
    int m;
    int over;
    do_reset();
    sample[DW +: DW] = 12'h100;
    strobe[1] = 1'b1;
    step();
    strobe[1] = 1'b0;
    vecs++;
    if (avg[DW +: DW] !== 12'h040 || avg_vld[1] !== 1'b1) begin
      errs++;
      $display("FAIL strobe_1st: avg1=%h vld=%b, want 040 1",
               avg[DW +: DW], avg_vld[1]);
    end
    step();
    vecs++;
    if (avg_vld[1] !== 1'b0) begin
      errs++;
      $display("FAIL strobe_idle: vld1=%b, want 0", avg_vld[1]);
    end
    strobe[1] = 1'b1;
    step();
    vecs++;
    if (avg[DW +: DW] !== 12'h070) begin
      errs++;
      $display("FAIL strobe_2nd: avg1=%h, want 070", avg[DW +: DW]);
    end
    m = 'h1C0;
    over = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      m = m - (m >> 2) + 'h100;
      if (avg[DW +: DW] > 12'h100) over++;
      if (int'(dut.acc_q[1]) > ('hFFF << 2)) over++;
      vecs++;
      if (int'(dut.acc_q[1]) !== m) begin
        errs++;
        $display("FAIL strobe_conv step%0d: acc1=%h, want %h",
                 i, dut.acc_q[1], m);
      end
    end
    strobe[1] = 1'b0;
    vecs++;
    if (over != 0 || avg[DW +: DW] !== 12'h100) begin
      errs++;
      $display("FAIL strobe_limit: avg1=%h overs=%0d, want 100 0",
               avg[DW +: DW], over);
    end
  endtask

  task automatic test_error();
    do_reset();
    sample[0 +: DW] = 12'h400;
    seed[0] = 1'b1;
    step();
    seed[0] = 1'b0;
    target = 12'h300;
    step();
    vecs++;
    if (error !== 13'h1F00) begin
      errs++;
      $display("FAIL err_neg: error=%h, want 1f00", error);
    end
    target = 12'h500;
    step();
    vecs++;
    if (error !== 13'h0100) begin
      errs++;
      $display("FAIL err_pos: error=%h, want 0100", error);
    end
    err_gate = 1'b1;
    step();
    vecs++;
    if (error !== 13'h0000) begin
      errs++;
      $display("FAIL err_gate: error=%h, want 0000", error);
    end
    err_gate = 1'b0;
  endtask

  task automatic test_clamp_reset();
    do_reset();
    sample[3*DW +: DW] = 12'h123;
    shift[9 +: 3] = 3'd7;
    seed[3] = 1'b1;
    strobe[3] = 1'b1;
    step();
    seed[3] = 1'b0;
    strobe[3] = 1'b0;
    vecs++;
    if (dut.acc_q[3] !== 17'h02460 || dut.sh_q[3] !== 3'd5) begin
      errs++;
      $display("FAIL clamp_acc: acc3=%h sh3=%0d, want 02460 5",
               dut.acc_q[3], dut.sh_q[3]);
    end
    vecs++;
    if (avg[3*DW +: DW] !== 12'h123 || avg_vld !== 4'b1000) begin
      errs++;
      $display("FAIL clamp_avg: avg3=%h vld=%b, want 123 1000",
               avg[3*DW +: DW], avg_vld);
    end
    step();
    vecs++;
    if (avg_vld !== 4'b0000) begin
      errs++;
      $display("FAIL clamp_pulse: vld=%b, want 0000", avg_vld);
    end
    shift[3 +: 3] = 3'd0;
    seed[1] = 1'b1;
    sample[DW +: DW] = 12'h0AB;
    step();
    seed[1] = 1'b0;
    vecs++;
    if (dut.sh_q[1] !== 3'd1 || dut.acc_q[1] !== 17'h00156) begin
      errs++;
      $display("FAIL clamp_zero: sh1=%0d acc1=%h, want 1 00156",
               dut.sh_q[1], dut.acc_q[1]);
    end
    sample = {4{12'hFFF}};
    target = 12'h555;
    strobe = '1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    strobe = '0;
    vecs++;
    if (avg !== '0 || avg_vld !== '0 || tick !== 1'b0 || error !== '0) begin
      errs++;
      $display("FAIL mid_reset: avg=%h vld=%b tick=%b err=%h, want all 0",
               avg, avg_vld, tick, error);
    end
    vecs++;
    if (dut.sh_q[3] !== 3'd2 || dut.sh_q[1] !== 3'd2) begin
      errs++;
      $display("FAIL mid_reset_sh: sh3=%0d sh1=%0d, want 2 2",
               dut.sh_q[3], dut.sh_q[1]);
    end
  endtask

`ifdef AVG_PEAK_HOLD_EN
  task automatic test_peak();
    do_reset();
    shift[0 +: 3] = 3'd1;
    sample[0 +: DW] = 12'h100;
    seed[0] = 1'b1;
    step();
    seed[0] = 1'b0;
    vecs++;
    if (avg[0 +: DW] !== 12'h100 || peak[0 +: DW] !== 12'h100) begin
      errs++;
      $display("FAIL peak_a: avg0=%h peak0=%h, want 100 100",
               avg[0 +: DW], peak[0 +: DW]);
    end
    sample[0 +: DW] = 12'h500;
    strobe[0] = 1'b1;
    step();
    vecs++;
    if (avg[0 +: DW] !== 12'h300 || peak[0 +: DW] !== 12'h300) begin
      errs++;
      $display("FAIL peak_b: avg0=%h peak0=%h, want 300 300",
               avg[0 +: DW], peak[0 +: DW]);
    end
    sample[0 +: DW] = 12'h100;
    step();
    strobe[0] = 1'b0;
    vecs++;
    if (avg[0 +: DW] !== 12'h200 || peak[0 +: DW] !== 12'h300) begin
      errs++;
      $display("FAIL peak_c: avg0=%h peak0=%h, want 200 300",
               avg[0 +: DW], peak[0 +: DW]);
    end
    sample[0 +: DW] = 12'h050;
    seed[0] = 1'b1;
    step();
    seed[0] = 1'b0;
    vecs++;
    if (peak[0 +: DW] !== 12'h050) begin
      errs++;
      $display("FAIL peak_seed: peak0=%h, want 050", peak[0 +: DW]);
    end
  endtask
`endif

  task automatic test_tick();
    int first_tick;
    int first_vld;
    int early;
    do_reset();
    mode[2] = 1'b0;
    sample[2*DW +: DW] = 12'h200;
    first_tick = -1;
    first_vld = -1;
    early = 0;
    for (int n = 1; n <= 65540; n++) begin
      step();
      if (tick && first_tick < 0) first_tick = n;
      if (avg_vld[2]) begin
        if (first_vld < 0) first_vld = n;
        if (n != 65536) early++;
      end
      if (avg_vld[0] || avg_vld[1] || avg_vld[3]) early++;
    end
    vecs++;
    if (first_tick != 65535) begin
      errs++;
      $display("FAIL tick_first: at %0d, want 65535", first_tick);
    end
    vecs++;
    if (first_vld != 65536 || early != 0) begin
      errs++;
      $display("FAIL tick_vld: first=%0d stray=%0d, want 65536 0",
               first_vld, early);
    end
    vecs++;
    if (avg[2*DW +: DW] !== 12'h080) begin
      errs++;
      $display("FAIL tick_avg: avg2=%h, want 080", avg[2*DW +: DW]);
    end
  endtask

  initial begin
    test_reset();
    test_seed();
    test_strobe();
    test_error();
    test_clamp_reset();
`ifdef AVG_PEAK_HOLD_EN
    test_peak();
`endif
    test_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
